jtframe_dump_ctrl: RTL and testbench
====================================

// Module: jtframe_dump_ctrl
// PURPOSE
//  Synthesizable, frame-windowed dump/capture trigger. Counts video frames from vs.
//  After an arm pulse, it opens capture windows on CH probe channels.
//  A window is single-shot or periodic, with start, length and period set in frames.
//  Sits beside the game core under the test harness.
//  Drives simulation dump on/off hooks or on-chip logic-analyser enables.
// PARAMETERS
//  FCW   32  frame counter / config width (bits)
//  CH    4   number of probe channels (dump_en width)
//  WCW   8   width of completed-window counter
// PORTS
//  clk          in   1    system clock
//  rst_n        in   1    asynchronous, active-low reset
//  vs           in   1    vertical sync, async to clk; falling edge = frame boundary
//  downloading  in   1    ROM download in progress (led)
//  arm          in   1    1-cycle pulse: latch cfg_*, start sequence
//  abort        in   1    1-cycle pulse: close any window, return to idle
//  cfg_start    in   FCW  frame number of first window start
//  cfg_len      in   FCW  window length in frames; 0 = open until abort
//  cfg_period   in   FCW  start-to-start distance; 0 = single-shot
//  cfg_mask     in   CH   channels enabled during a window
//  frame_cnt    out  FCW  frames since end of download (wraps)
//  dump_en      out  CH   per-channel capture enable
//  dump_start   out  1    1-cycle pulse when a window opens
//  dump_stop    out  1    1-cycle pulse when a window closes
//  busy         out  1    high in WAIT or DUMP
//  windows      out  WCW  completed windows since arm; saturates at all-ones
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - All outputs and internal registers go to 0; FSM goes to IDLE.
//  Frame tick:
//   - vs passes through a 2-FF synchroniser and then a falling-edge detector.
//   - tick is high for 1 clk, 3 clk edges after vs falls.
//  frame_cnt:
//   - Held at 0 while downloading.
//   - Otherwise increments by 1 on each tick and wraps from 2^FCW-1 to 0.
//  FSM states IDLE/WAIT/DUMP; registered outputs, no combinational paths from inputs.
//  IDLE:
//   - arm with downloading=0 latches the cfg_* fields and sets nxt=cfg_start.
//   - If cfg_period!=0 and cfg_period<=cfg_len, latched period is forced to cfg_len+1.
//   - If cfg_start==frame_cnt, go to DUMP next cycle; else go to WAIT.
//   - arm while downloading=1 is ignored.
//  WAIT:
//   - On a tick with frame_cnt+1==nxt, go to DUMP. frame_cnt and dump_en update on the same edge.
//   - A start frame already passed is reached after frame_cnt wraps.
//  DUMP entry:
//   - dump_en=mask; dump_start pulses; len_cnt clears.
//  DUMP:
//   - On each tick, len_cnt increments (len_cnt+1 used for the compare).
//   - When len!=0 and len_cnt+1==len:
//     - dump_en goes to 0 and dump_stop pulses.
//     - windows increments, saturating.
//     - If period==0, go to IDLE.
//     - Else nxt=nxt+period (mod 2^FCW) and go to WAIT.
//   - With len==0 the window stays open until abort or download.
//  abort or downloading rising, any state:
//   - Next cycle: IDLE, dump_en=0.
//   - dump_stop pulses only if the state was DUMP.
//   - windows is not incremented.
//  Priority and ignored inputs:
//   - abort beats arm in the same cycle; download beats both.
//   - arm outside IDLE is ignored; cfg_* is sampled only on an accepted arm.
//  busy = (state!=IDLE).
//  dump_start/dump_stop are never high outside the cycle after a transition.
// STRUCTURE
//  Package jtframe_dump_pkg:
//   - state enum {IDLE,WAIT,DUMP}.
//   - Default widths FCW/CH/WCW.
//  Sub-module jtframe_dump_sync:
//   - 2-FF synchroniser plus falling-edge tick; reset to 0 so no spurious tick is produced.
//  Top module holds frame_cnt, the FSM, len_cnt, nxt, the latched cfg and the windows counter.
// TESTING
//  1. downloading=1 for 5 frames, then 0; arm start=3 len=2 period=0 mask=4'b0101:
//     - dump_en=0101 during frame_cnt 3..4, then 0.
//     - 1 start pulse and 1 stop pulse; windows=1; busy=0.
//  2. start=2 len=1 period=4, run 12 frames:
//     - Windows at frames 2, 6 and 10; windows=3 at frame 11.
//  3. len=3 period=2:
//     - period forced to 4; windows at 0..2 and 4..6, never continuous.
//  4. FCW=4, arm at frame_cnt=9 with start=2:
//     - Waits through the wrap; dump_en rises when frame_cnt becomes 2.
//  5. abort in DUMP, then in WAIT:
//     - In DUMP: dump_stop pulses, dump_en=0 next clk, windows unchanged.
//     - In WAIT: no dump_stop; busy=0.
//  6. Other events:
//     - arm and abort in the same cycle: stays IDLE.
//     - downloading rises mid-window: IDLE, frame_cnt=0.
//     - rst_n low mid-window: all outputs 0 asynchronously.

Source files
------------

// File: rtl/jtframe_dump_pkg.sv
// Shared types and default widths for the frame-windowed dump trigger.
// Imported by the synchroniser and by the controller top.
package jtframe_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DUMP = 2'd2
  } state_t;

  localparam int FCW_DEF = 32;
  localparam int CH_DEF  = 4;
  localparam int WCW_DEF = 8;

endpackage

// File: rtl/jtframe_dump_sync.sv
// Brings vs into the clk domain and turns its falling edge into a one-cycle frame tick.
// All stages reset low, so a vs that is already high at reset release cannot fake a tick.
module jtframe_dump_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic vs,
  output logic tick
);

  logic [2:0] sh;

  // sh[1:0] is the two-flop synchroniser; sh[2] holds the previous synchronised level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      tick <= 1'b0;
    end else begin
      sh   <= {sh[1:0], vs};
      tick <= sh[2] & ~sh[1];
    end
  end

endmodule

// File: rtl/jtframe_dump_ctrl.sv
// Frame-windowed capture trigger: counts frames from vs and, once armed, opens
// single-shot or periodic capture windows on the probe channels.
module jtframe_dump_ctrl
  import jtframe_dump_pkg::*;
#(
  parameter int FCW = FCW_DEF,
  parameter int CH  = CH_DEF,
  parameter int WCW = WCW_DEF
)(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           vs,
  input  logic           downloading,
  input  logic           arm,
  input  logic           abort,
  input  logic [FCW-1:0] cfg_start,
  input  logic [FCW-1:0] cfg_len,
  input  logic [FCW-1:0] cfg_period,
  input  logic [CH-1:0]  cfg_mask,
  output logic [FCW-1:0] frame_cnt,
  output logic [CH-1:0]  dump_en,
  output logic           dump_start,
  output logic           dump_stop,
  output logic           busy,
  output logic [WCW-1:0] windows
);

  localparam logic [FCW-1:0] FONE = FCW'(1);
  localparam logic [WCW-1:0] WONE = WCW'(1);

  state_t         state;
  logic           tick;
  logic [FCW-1:0] nxt;
  logic [FCW-1:0] len_q;
  logic [FCW-1:0] per_q;
  logic [CH-1:0]  mask_q;
  logic [FCW-1:0] len_cnt;
  logic [FCW-1:0] frame_nx;
  logic [FCW-1:0] len_nx;
  logic [FCW-1:0] per_eff;

  jtframe_dump_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .vs    (vs),
    .tick  (tick)
  );

  assign frame_nx = frame_cnt + FONE;
  assign len_nx   = len_cnt + FONE;
  assign busy     = (state != IDLE);

  // A period no longer than the window would make windows touch or overlap
  assign per_eff = (cfg_period != '0 && cfg_period <= cfg_len) ? cfg_len + FONE : cfg_period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= '0;
    else if (downloading)
      frame_cnt <= '0;
    else if (tick)
      frame_cnt <= frame_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      nxt        <= '0;
      len_q      <= '0;
      per_q      <= '0;
      mask_q     <= '0;
      len_cnt    <= '0;
      dump_en    <= '0;
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
      windows    <= '0;
    end else begin
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
      if (downloading || abort) begin
        if (state == DUMP) dump_stop <= 1'b1;
        state   <= IDLE;
        dump_en <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (arm) begin
              len_q   <= cfg_len;
              per_q   <= per_eff;
              mask_q  <= cfg_mask;
              nxt     <= cfg_start;
              len_cnt <= '0;
              windows <= '0;
              if (cfg_start == frame_cnt) begin
                state      <= DUMP;
                dump_en    <= cfg_mask;
                dump_start <= 1'b1;
              end else begin
                state <= WAIT;
              end
            end
          end
          WAIT: begin
            if (tick && frame_nx == nxt) begin
              state      <= DUMP;
              dump_en    <= mask_q;
              dump_start <= 1'b1;
              len_cnt    <= '0;
            end
          end
          DUMP: begin
            if (tick) begin
              len_cnt <= len_nx;
              // A zero length keeps the window open until abort or download
              if (len_q != '0 && len_nx == len_q) begin
                dump_en   <= '0;
                dump_stop <= 1'b1;
                if (windows != '1) windows <= windows + WONE;
                if (per_q == '0) begin
                  state <= IDLE;
                end else begin
                  nxt   <= nxt + per_q;
                  state <= WAIT;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
// Randomised bench for jtframe_dump_ctrl, checked frame by frame against a window
// timeline model (window k opens d0+k*P ticks after arm and lasts len ticks).
module tb_jtframe_dump_ctrl;

  localparam int FCW  = 4;
  localparam int CH   = 4;
  localparam int WCW  = 3;
  localparam int FMOD = 16;
  localparam int WSAT = 7;

  logic           clk;
  logic           rst_n;
  logic           vs;
  logic           downloading;
  logic           arm;
  logic           abort;
  logic [FCW-1:0] cfg_start;
  logic [FCW-1:0] cfg_len;
  logic [FCW-1:0] cfg_period;
  logic [CH-1:0]  cfg_mask;
  logic [FCW-1:0] frame_cnt;
  logic [CH-1:0]  dump_en;
  logic           dump_start;
  logic           dump_stop;
  logic           busy;
  logic [WCW-1:0] windows;

  jtframe_dump_ctrl #(.FCW(FCW), .CH(CH), .WCW(WCW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vs          (vs),
    .downloading (downloading),
    .arm         (arm),
    .abort       (abort),
    .cfg_start   (cfg_start),
    .cfg_len     (cfg_len),
    .cfg_period  (cfg_period),
    .cfg_mask    (cfg_mask),
    .frame_cnt   (frame_cnt),
    .dump_en     (dump_en),
    .dump_start  (dump_start),
    .dump_stop   (dump_stop),
    .busy        (busy),
    .windows     (windows)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int start_seen = 0;
  int stop_seen  = 0;

  always @(posedge clk) begin
    if (dump_start) start_seen++;
    if (dump_stop)  stop_seen++;
  end

  int fc;
  bit m_armed;
  int m_d0, m_len, m_per, m_mask, m_t;
  int base_s, base_p;
  int tot_s, tot_p;
  int idle_win;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int opensUpto(input int t);
    if (t < m_d0) return 0;
    if (m_per == 0) return 1;
    return (t - m_d0) / m_per + 1;
  endfunction

  function automatic int closesUpto(input int t);
    if (m_len == 0 || t < m_d0 + m_len) return 0;
    if (m_per == 0) return 1;
    return (t - m_d0 - m_len) / m_per + 1;
  endfunction

  function automatic bit windowOpen(input int t);
    if (m_len == 0) return opensUpto(t) > 0;
    return opensUpto(t) > closesUpto(t);
  endfunction

  function automatic int startsUpto(input int t);
    if (m_len == 0) return (opensUpto(t) > 0) ? 1 : 0;
    return opensUpto(t);
  endfunction

  function automatic bit modelBusy();
    if (!m_armed) return 1'b0;
    if (m_len == 0 || m_per != 0) return 1'b1;
    return closesUpto(m_t) == 0;
  endfunction

  function automatic int minSat(input int v);
    return (v > WSAT) ? WSAT : v;
  endfunction

  task automatic endTrial(input bit stop_now);
    if (m_armed) begin
      tot_s = base_s + startsUpto(m_t);
      tot_p = base_p + closesUpto(m_t) + ((stop_now && windowOpen(m_t)) ? 1 : 0);
      idle_win = minSat(closesUpto(m_t));
      m_armed = 1'b0;
    end
  endtask

  task automatic modelArm(input int s, input int l, input int p, input int m);
    if (modelBusy()) return;
    endTrial(1'b0);
    m_armed = 1'b1;
    m_d0    = (s - fc + FMOD) % FMOD;
    m_len   = l;
    m_per   = (p != 0 && p <= l) ? l + 1 : p;
    m_mask  = m;
    m_t     = 0;
    base_s  = tot_s;
    base_p  = tot_p;
  endtask

  task automatic checkModel(input string ctx);
    int e_en, e_busy, e_win, e_s, e_p;
    if (m_armed) begin
      e_en   = windowOpen(m_t) ? m_mask : 0;
      e_busy = modelBusy() ? 1 : 0;
      e_win  = minSat(closesUpto(m_t));
      e_s    = base_s + startsUpto(m_t);
      e_p    = base_p + closesUpto(m_t);
    end else begin
      e_en   = 0;
      e_busy = 0;
      e_win  = idle_win;
      e_s    = tot_s;
      e_p    = tot_p;
    end
    checkOutput({ctx, ".frame_cnt"}, 32'(frame_cnt), 32'(fc));
    checkOutput({ctx, ".dump_en"},   32'(dump_en),   32'(e_en));
    checkOutput({ctx, ".busy"},      32'(busy),      32'(e_busy));
    checkOutput({ctx, ".windows"},   32'(windows),   32'(e_win));
    checkOutput({ctx, ".starts"},    32'(start_seen), 32'(e_s));
    checkOutput({ctx, ".stops"},     32'(stop_seen),  32'(e_p));
  endtask

  task automatic checkReset(input string ctx);
    checkOutput({ctx, ".frame_cnt"},  32'(frame_cnt),  32'd0);
    checkOutput({ctx, ".dump_en"},    32'(dump_en),    32'd0);
    checkOutput({ctx, ".busy"},       32'(busy),       32'd0);
    checkOutput({ctx, ".windows"},    32'(windows),    32'd0);
    checkOutput({ctx, ".dump_start"}, 32'(dump_start), 32'd0);
    checkOutput({ctx, ".dump_stop"},  32'(dump_stop),  32'd0);
  endtask

  task automatic genFrame();
    @(negedge clk) vs = 1'b0;
    repeat (6) @(negedge clk);
    vs = 1'b1;
    repeat (5) @(negedge clk);
    if (!downloading) fc = (fc + 1) % FMOD;
    if (m_armed) m_t++;
  endtask

  task automatic applyStimulus(input int s, input int l, input int p, input int m, input bit with_abort);
    @(negedge clk);
    cfg_start  = FCW'(s);
    cfg_len    = FCW'(l);
    cfg_period = FCW'(p);
    cfg_mask   = CH'(m);
    arm        = 1'b1;
    abort      = with_abort;
    @(negedge clk);
    arm   = 1'b0;
    abort = 1'b0;
    if (with_abort) endTrial(1'b1);
    else if (!downloading) modelArm(s, l, p, m);
    @(negedge clk);
  endtask

  task automatic pulseAbort();
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    endTrial(1'b1);
    @(negedge clk);
  endtask

  task automatic setDownload(input bit v);
    @(negedge clk) downloading = v;
    if (v) begin
      endTrial(1'b1);
      fc = 0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic gotoFrame(input int target);
    for (int i = 0; i < FMOD + 2 && fc != target; i++) genFrame();
  endtask

  task automatic runTrial(input int s, input int l, input int p, input int m, input int nframes, input bit try_rearm);
    applyStimulus(s, l, p, m, 1'b0);
    checkModel("arm");
    for (int i = 0; i < nframes; i++) begin
      genFrame();
      checkModel("frame");
      if (try_rearm && i == nframes / 2 && modelBusy()) begin
        applyStimulus($urandom_range(0, FMOD - 1), $urandom_range(0, 6),
                      $urandom_range(0, 9), $urandom_range(1, 15), 1'b0);
        checkModel("rearm");
      end
    end
    pulseAbort();
    checkModel("abort");
  endtask

  initial begin
    rst_n       = 1'b0;
    vs          = 1'b1;
    downloading = 1'b1;
    arm         = 1'b0;
    abort       = 1'b0;
    cfg_start   = '0;
    cfg_len     = '0;
    cfg_period  = '0;
    cfg_mask    = '0;
    fc = 0; m_armed = 1'b0; m_t = 0; m_d0 = 0; m_len = 0; m_per = 0; m_mask = 0;
    base_s = 0; base_p = 0; tot_s = 0; tot_p = 0; idle_win = 0;

    repeat (3) @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      genFrame();
      checkModel("download");
    end
    applyStimulus(0, 1, 0, 4'hF, 1'b0);
    checkModel("arm_while_download");
    setDownload(1'b0);
    checkModel("download_done");

    $display("[TB] single shot window");
    runTrial(3, 2, 0, 4'b0101, 8, 1'b0);

    $display("[TB] periodic window");
    gotoFrame(1);
    runTrial(2, 1, 4, 4'b1010, 12, 1'b0);

    $display("[TB] period forced above length");
    gotoFrame(0);
    runTrial(0, 3, 2, 4'b0011, 10, 1'b0);

    $display("[TB] start frame reached through wrap");
    gotoFrame(9);
    runTrial(2, 2, 0, 4'b1111, 12, 1'b0);

    $display("[TB] windows counter saturation");
    runTrial(fc, 1, 2, 4'b1001, 20, 1'b0);

    $display("[TB] abort in DUMP and in WAIT");
    runTrial((fc + 1) % FMOD, 0, 0, 4'b0110, 4, 1'b1);
    runTrial((fc + 10) % FMOD, 2, 0, 4'b1100, 3, 1'b0);

    $display("[TB] arm and abort together");
    applyStimulus(fc, 2, 0, 4'b1111, 1'b1);
    checkModel("arm_abort");

    $display("[TB] random trials");
    for (int n = 0; n < 20; n++) begin
      runTrial($urandom_range(0, FMOD - 1), $urandom_range(0, 6), $urandom_range(0, 9),
               $urandom_range(1, 15), $urandom_range(4, 24), 1'b1);
    end

    $display("[TB] download during window");
    applyStimulus(fc, 0, 0, 4'b0101, 1'b0);
    genFrame();
    checkModel("pre_download");
    setDownload(1'b1);
    checkModel("download_rise");
    genFrame();
    checkModel("download_hold");
    setDownload(1'b0);
    checkModel("download_fall");

    $display("[TB] reset during window");
    applyStimulus(fc, 0, 0, 4'b1111, 1'b0);
    genFrame();
    checkModel("pre_reset");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkReset("async_reset");
    endTrial(1'b0);
    fc = 0;
    idle_win = 0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkModel("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
